// File: rtl/posture_th_monitor.sv
// Per-pixel y/angle threshold flags (2-cycle pipeline) with per-frame violation counts and debounced alarms.
// Build option: define ANGLE_EXCL_EN to enable the angle exclusion-value compare.
module posture_th_monitor #(
    parameter int Y_DATA_WID     = 11,
    parameter int ANGLE_DATA_WID = 7,
    parameter int TH_WID         = 11,
    parameter int CNT_WID        = 20,
    parameter int PERSIST        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [Y_DATA_WID-1:0]     y_data,
    input  logic [ANGLE_DATA_WID-1:0] angle_data,
    input  logic [TH_WID-1:0]         y_min,
    input  logic [TH_WID-1:0]         y_max,
    input  logic [TH_WID-1:0]         angle_th,
    input  logic [TH_WID-1:0]         angle_excl,
    input  logic [CNT_WID-1:0]        pix_cnt_th,
    input  logic                      vs_in,
    input  logic                      de_in,
    output logic                      y_th_flag,
    output logic                      angle_th_flag,
    output logic                      vs_out,
    output logic                      de_out,
    output logic [CNT_WID-1:0]        y_frame_cnt,
    output logic [CNT_WID-1:0]        ang_frame_cnt,
    output logic                      y_alarm,
    output logic                      angle_alarm,
    output logic                      frame_done
);

    localparam int YC_W = (Y_DATA_WID > TH_WID) ? Y_DATA_WID : TH_WID;
    localparam int AC_W = (ANGLE_DATA_WID > TH_WID) ? ANGLE_DATA_WID : TH_WID;
    localparam logic [CNT_WID-1:0] CNT_MAX     = {CNT_WID{1'b1}};
    localparam logic [3:0]         PERSIST_MAX = 4'(PERSIST);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        COUNT   = 2'd1,
        EVAL    = 2'd2
    } state_t;

    function automatic logic [CNT_WID-1:0] sat_add(input logic [CNT_WID-1:0] cnt,
                                                   input logic inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + CNT_WID'(1);
        end
        return cnt;
    endfunction

    function automatic logic [3:0] persist_next(input logic [3:0] p, input logic over);
        if (!over) begin
            return 4'd0;
        end
        if (p >= PERSIST_MAX) begin
            return PERSIST_MAX;
        end
        return p + 4'd1;
    endfunction

    logic [Y_DATA_WID-1:0]     y_s1_q;
    logic [ANGLE_DATA_WID-1:0] ang_s1_q;
    logic [TH_WID-1:0]         ymin_s1_q;
    logic [TH_WID-1:0]         ymax_s1_q;
    logic [TH_WID-1:0]         ath_s1_q;
    logic                      de_s1_q;
    logic                      vs_s1_q;
`ifdef ANGLE_EXCL_EN
    logic [TH_WID-1:0]         aex_s1_q;
    logic [AC_W-1:0]           aex_ext;
`else
    logic                      excl_unused;
    assign excl_unused = ^angle_excl;
`endif

    logic [YC_W-1:0] y_ext, ymin_ext, ymax_ext;
    logic [AC_W-1:0] ang_ext, ath_ext;
    logic            y_flag_d, ang_flag_d;

    logic            y_flag_q, ang_flag_q, vs_s2_q, de_s2_q;

    state_t             state_q;
    logic               vs_prev_q;
    logic               vs_rise;
    logic [CNT_WID-1:0] y_cnt_q, ang_cnt_q;
    logic [CNT_WID-1:0] y_fcnt_q, ang_fcnt_q;
    logic [3:0]         y_pers_q, ang_pers_q;
    logic [3:0]         y_pers_d, ang_pers_d;
    logic               y_alarm_q, ang_alarm_q, frame_done_q;

    // Stage 1: register pixel data, sync and the live thresholds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_s1_q    <= '0;
            ang_s1_q  <= '0;
            ymin_s1_q <= '0;
            ymax_s1_q <= '0;
            ath_s1_q  <= '0;
            de_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
`ifdef ANGLE_EXCL_EN
            aex_s1_q  <= '0;
`endif
        end else begin
            y_s1_q    <= y_data;
            ang_s1_q  <= angle_data;
            ymin_s1_q <= y_min;
            ymax_s1_q <= y_max;
            ath_s1_q  <= angle_th;
            de_s1_q   <= de_in;
            vs_s1_q   <= vs_in;
`ifdef ANGLE_EXCL_EN
            aex_s1_q  <= angle_excl;
`endif
        end
    end

    // Stage 2: compare in a common zero-extended width; an inverted y window flags every pixel
    always_comb begin
        y_ext    = YC_W'(y_s1_q);
        ymin_ext = YC_W'(ymin_s1_q);
        ymax_ext = YC_W'(ymax_s1_q);
        ang_ext  = AC_W'(ang_s1_q);
        ath_ext  = AC_W'(ath_s1_q);
        y_flag_d = de_s1_q & ((y_ext < ymin_ext) | (y_ext > ymax_ext));
`ifdef ANGLE_EXCL_EN
        aex_ext    = AC_W'(aex_s1_q);
        ang_flag_d = de_s1_q & ((ang_ext > ath_ext) | (ang_ext == aex_ext));
`else
        ang_flag_d = de_s1_q & (ang_ext > ath_ext);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_flag_q   <= 1'b0;
            ang_flag_q <= 1'b0;
            vs_s2_q    <= 1'b0;
            de_s2_q    <= 1'b0;
        end else begin
            y_flag_q   <= y_flag_d;
            ang_flag_q <= ang_flag_d;
            vs_s2_q    <= vs_s1_q;
            de_s2_q    <= de_s1_q;
        end
    end

    // Frame control: driven by the stage-2 stream so counts line up with the visible flags
    assign vs_rise = vs_s2_q & ~vs_prev_q;

    always_comb begin
        y_pers_d   = persist_next(y_pers_q, y_cnt_q > pix_cnt_th);
        ang_pers_d = persist_next(ang_pers_q, ang_cnt_q > pix_cnt_th);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_VS;
            vs_prev_q    <= 1'b0;
            y_cnt_q      <= '0;
            ang_cnt_q    <= '0;
            y_fcnt_q     <= '0;
            ang_fcnt_q   <= '0;
            y_pers_q     <= 4'd0;
            ang_pers_q   <= 4'd0;
            y_alarm_q    <= 1'b0;
            ang_alarm_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            vs_prev_q    <= vs_s2_q;
            frame_done_q <= 1'b0;
            unique case (state_q)
                WAIT_VS: begin
                    if (vs_rise) begin
                        state_q   <= COUNT;
                        y_cnt_q   <= '0;
                        ang_cnt_q <= '0;
                    end
                end
                COUNT: begin
                    y_cnt_q   <= sat_add(y_cnt_q, y_flag_q);
                    ang_cnt_q <= sat_add(ang_cnt_q, ang_flag_q);
                    if (vs_rise) begin
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    y_fcnt_q     <= y_cnt_q;
                    ang_fcnt_q   <= ang_cnt_q;
                    y_pers_q     <= y_pers_d;
                    ang_pers_q   <= ang_pers_d;
                    y_alarm_q    <= (y_pers_d == PERSIST_MAX);
                    ang_alarm_q  <= (ang_pers_d == PERSIST_MAX);
                    frame_done_q <= 1'b1;
                    // The flag seen during this cycle already belongs to the new frame
                    y_cnt_q      <= CNT_WID'(y_flag_q);
                    ang_cnt_q    <= CNT_WID'(ang_flag_q);
                    state_q      <= COUNT;
                end
                default: begin
                    state_q <= WAIT_VS;
                end
            endcase
        end
    end

    assign y_th_flag     = y_flag_q;
    assign angle_th_flag = ang_flag_q;
    assign vs_out        = vs_s2_q;
    assign de_out        = de_s2_q;
    assign y_frame_cnt   = y_fcnt_q;
    assign ang_frame_cnt = ang_fcnt_q;
    assign y_alarm       = y_alarm_q;
    assign angle_alarm   = ang_alarm_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_posture_th_monitor.sv
// Randomized and directed bench for posture_th_monitor with a stream-level reference model.
module tb_posture_th_monitor;

    localparam int YW     = 11;
    localparam int AW     = 7;
    localparam int TW     = 11;
    localparam int CW     = 4;
    localparam int PERS   = 3;
    localparam int SATMAX = (1 << CW) - 1;
    localparam int MAXC   = 8;
`ifdef ANGLE_EXCL_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [YW-1:0] y_data = '0;
    logic [AW-1:0] angle_data = '0;
    logic [TW-1:0] y_min = 11'd100;
    logic [TW-1:0] y_max = 11'd300;
    logic [TW-1:0] angle_th = 11'd60;
    logic [TW-1:0] angle_excl = 11'd90;
    logic [CW-1:0] pix_cnt_th = 4'd10;
    logic          vs_in = 1'b0;
    logic          de_in = 1'b0;
    logic          y_th_flag, angle_th_flag, vs_out, de_out;
    logic [CW-1:0] y_frame_cnt, ang_frame_cnt;
    logic          y_alarm, angle_alarm, frame_done;

    posture_th_monitor #(
        .Y_DATA_WID(YW), .ANGLE_DATA_WID(AW), .TH_WID(TW), .CNT_WID(CW), .PERSIST(PERS)
    ) dut (
        .clk(clk), .rst(rst), .y_data(y_data), .angle_data(angle_data),
        .y_min(y_min), .y_max(y_max), .angle_th(angle_th), .angle_excl(angle_excl),
        .pix_cnt_th(pix_cnt_th), .vs_in(vs_in), .de_in(de_in),
        .y_th_flag(y_th_flag), .angle_th_flag(angle_th_flag), .vs_out(vs_out), .de_out(de_out),
        .y_frame_cnt(y_frame_cnt), .ang_frame_cnt(ang_frame_cnt),
        .y_alarm(y_alarm), .angle_alarm(angle_alarm), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: per-edge input history, expected stream two edges later, frame bookkeeping on that stream
    int h_y[MAXC], h_a[MAXC], h_ymin[MAXC], h_ymax[MAXC], h_ath[MAXC], h_aex[MAXC];
    bit h_de[MAXC], h_vs[MAXC], h_rst[MAXC];
    int cyc = 0;
    int cur, prv;
    bit e_yf, e_af, e_vs, e_de, e_fd, e_ya, e_aa;
    int e_yc, e_ac;
    bit armed, prev_vs;
    int ycnt, acnt, ypers, apers, pend_at, pend_y, pend_a;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        pend_at = -1;
        forever begin
            @(posedge clk);
            cur = cyc % MAXC;
            prv = (cyc + MAXC - 1) % MAXC;
            h_y[cur] = int'(y_data);    h_a[cur] = int'(angle_data);
            h_ymin[cur] = int'(y_min);  h_ymax[cur] = int'(y_max);
            h_ath[cur] = int'(angle_th); h_aex[cur] = int'(angle_excl);
            h_de[cur] = de_in; h_vs[cur] = vs_in; h_rst[cur] = rst;
            if (rst || cyc == 0 || h_rst[prv]) begin
                e_vs = 0; e_de = 0; e_yf = 0; e_af = 0;
            end else begin
                e_vs = h_vs[prv];
                e_de = h_de[prv];
                e_yf = h_de[prv] && (h_y[prv] < h_ymin[prv] || h_y[prv] > h_ymax[prv]);
                e_af = h_de[prv] && (h_a[prv] > h_ath[prv] || (EXCL && h_a[prv] == h_aex[prv]));
            end
            if (rst) begin
                armed = 0; prev_vs = 0; ycnt = 0; acnt = 0; ypers = 0; apers = 0; pend_at = -1;
                e_fd = 0; e_yc = 0; e_ac = 0; e_ya = 0; e_aa = 0;
            end else begin
                e_fd = 0;
                if (pend_at == cyc) begin
                    e_fd = 1; e_yc = pend_y; e_ac = pend_a;
                    ypers = (pend_y > int'(pix_cnt_th)) ? imin(ypers + 1, PERS) : 0;
                    apers = (pend_a > int'(pix_cnt_th)) ? imin(apers + 1, PERS) : 0;
                    e_ya = (ypers == PERS);
                    e_aa = (apers == PERS);
                    pend_at = -1;
                end
                if (e_vs && !prev_vs) begin
                    if (armed) begin
                        pend_y = imin(ycnt + int'(e_yf), SATMAX);
                        pend_a = imin(acnt + int'(e_af), SATMAX);
                        pend_at = cyc + 2;
                    end
                    armed = 1; ycnt = 0; acnt = 0;
                end else if (armed) begin
                    ycnt += int'(e_yf);
                    acnt += int'(e_af);
                end
                prev_vs = e_vs;
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("y_th_flag", int'(y_th_flag), int'(e_yf));
            chk("angle_th_flag", int'(angle_th_flag), int'(e_af));
            chk("vs_out", int'(vs_out), int'(e_vs));
            chk("de_out", int'(de_out), int'(e_de));
            chk("frame_done", int'(frame_done), int'(e_fd));
            chk("y_frame_cnt", int'(y_frame_cnt), e_yc);
            chk("ang_frame_cnt", int'(ang_frame_cnt), e_ac);
            chk("y_alarm", int'(y_alarm), int'(e_ya));
            chk("angle_alarm", int'(angle_alarm), int'(e_aa));
        end
    end

    task automatic drv(input int y, input int a, input bit de, input bit vs);
        @(negedge clk);
        y_data = y[YW-1:0];
        angle_data = a[AW-1:0];
        de_in = de;
        vs_in = vs;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(200, 0, 1'b0, 1'b0);
    endtask

    task automatic vsync(input int n);
        repeat (n) drv(0, 0, 1'b0, 1'b1);
    endtask

    task automatic y_px(input int n);
        repeat (n) drv(50, 0, 1'b1, 1'b0);
    endtask

    task automatic px_chk(input string name, input int y, input int a, input bit de,
                          input int ey, input int ea);
        drv(y, a, de, 1'b0);
        drv(200, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk({name, "_yflag"}, int'(y_th_flag), ey);
        chk({name, "_aflag"}, int'(angle_th_flag), ea);
    endtask

    task automatic wait_fd(output bit seen);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) seen = 1;
        end
    endtask

    task automatic close_chk(input string name, input int ecnt, input int ealarm);
        bit seen;
        vsync(2);
        idle(1);
        wait_fd(seen);
        chk({name, "_done"}, int'(seen), 1);
        chk({name, "_ycnt"}, int'(y_frame_cnt), ecnt);
        chk({name, "_yalarm"}, int'(y_alarm), ealarm);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int npx, r;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        px_chk("y99", 99, 0, 1'b1, 1, 0);
        px_chk("y100", 100, 0, 1'b1, 0, 0);
        px_chk("y300", 300, 0, 1'b1, 0, 0);
        px_chk("y301", 301, 0, 1'b1, 1, 0);
        px_chk("y99_de0", 99, 0, 1'b0, 0, 0);
        px_chk("y301_de0", 301, 100, 1'b0, 0, 0);
        px_chk("ang60", 200, 60, 1'b1, 0, 0);
        px_chk("ang61", 200, 61, 1'b1, 0, 1);
        px_chk("ang90", 200, 90, 1'b1, 0, 1);
        angle_th = 11'd100;
        px_chk("ang90_th100", 200, 90, 1'b1, 0, EXCL ? 1 : 0);
        angle_th = 11'd60;
        y_min = 11'd300; y_max = 11'd100;
        px_chk("inverted_window", 200, 0, 1'b1, 1, 0);
        y_min = 11'd100; y_max = 11'd300;

        y_px(4);
        vsync(2);
        idle(1);
        wait_fd(seen);
        chk("first_vs_no_done", int'(seen), 0);

        y_px(11); close_chk("persist1", 11, 0);
        y_px(11); close_chk("persist2", 11, 0);
        y_px(11); close_chk("persist3", 11, 1);
        y_px(10); close_chk("clear_at10", 10, 0);
        y_px(20); close_chk("saturate", 15, 0);

        y_px(5);
        drv(0, 0, 1'b0, 1'b1);
        drv(50, 0, 1'b1, 1'b1);
        idle(1);
        wait_fd(seen);
        chk("eval_px_done", int'(seen), 1);
        chk("eval_px_prev", int'(y_frame_cnt), 5);
        close_chk("eval_px_new", 1, 0);

        y_px(11); close_chk("pre_rst1", 11, 0);
        y_px(11); close_chk("pre_rst2", 11, 0);
        y_px(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_zero",
            int'({y_th_flag, angle_th_flag, vs_out, de_out, frame_done, y_alarm, angle_alarm})
            | int'(y_frame_cnt) | int'(ang_frame_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1);
        vsync(2);
        idle(1);
        wait_fd(seen);
        chk("rst_first_vs_no_done", int'(seen), 0);
        y_px(11); close_chk("post_rst", 11, 0);

        for (int f = 0; f < 50; f++) begin
            pix_cnt_th = 4'($urandom_range(2, 14));
            if ($urandom_range(0, 11) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(2, 5)) begin
                    drv(50, 95, 1'b1, 1'b1);
                    drv(50, 10, 1'b1, 1'b0);
                end
            end
            vsync($urandom_range(1, 3));
            idle($urandom_range(0, 2));
            npx = $urandom_range(5, 40);
            for (int p = 0; p < npx; p++) begin
                if ($urandom_range(0, 9) == 0) begin
                    y_min = 11'($urandom_range(50, 250));
                    y_max = 11'($urandom_range(150, 350));
                    angle_th = 11'($urandom_range(30, 130));
                    angle_excl = 11'($urandom_range(60, 127));
                end
                r = ($urandom_range(0, 4) == 0) ? int'(angle_excl) : int'($urandom_range(0, 127));
                drv($urandom_range(0, 400), r, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 30) == 0);
            end
        end
        vsync(2);
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
